// File: rtl/seg_scan_display_if.sv
// Bus between the datapath debug taps and the 8-digit scanned seven-segment display.
// The master supplies values to show; the slave drives segments, enables and scan status.
interface seg_scan_display_if;
  logic        load;
  logic [15:0] number_a;
  logic [15:0] number_b;
  logic [6:0]  out7;
  logic [7:0]  en_out;
  logic [2:0]  digit_idx;
  logic        frame_done;

  modport master (
    output load, number_a, number_b,
    input  out7, en_out, digit_idx, frame_done
  );

  modport slave (
    input  load, number_a, number_b,
    output out7, en_out, digit_idx, frame_done
  );
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 8-digit hex display driver: captures two 16-bit values and scans one digit
// per REFRESH_DIV clocks, with optional leading-zero blanking per 4-digit group.
module seg_scan_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seg_scan_display_if.slave bus
);

  localparam int unsigned      CntW   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_digit_idx;
  logic            r_frame_done;
  logic [15:0]     r_a;
  logic [15:0]     r_b;

  logic            w_adv;
  logic [15:0]     w_group;
  logic [1:0]      w_sel;
  logic [3:0]      w_nibble;
  logic            w_blank;
  logic [6:0]      w_glyph;

  assign w_adv = (r_cnt == CntMax);

  // Capture and scan advance are independent so a load on an advance edge is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_digit_idx  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (bus.load) begin
        r_a <= bus.number_a;
        r_b <= bus.number_b;
      end
      r_cnt        <= w_adv ? '0 : r_cnt + CntW'(1);
      r_frame_done <= w_adv && (r_digit_idx == 3'd7);
      if (w_adv) begin
        r_digit_idx <= r_digit_idx + 3'd1;
      end
    end
  end

  assign w_group  = r_digit_idx[2] ? r_b : r_a;
  assign w_sel    = r_digit_idx[1:0];
  assign w_nibble = w_group[{w_sel, 2'b00} +: 4];

  // A digit blanks only if it and every more significant digit of its group are zero.
  always_comb begin
    w_blank = 1'b0;
    unique case (w_sel)
      2'd0: w_blank = 1'b0;
      2'd1: w_blank = (w_group[15:4] == 12'h000);
      2'd2: w_blank = (w_group[15:8] == 8'h00);
      2'd3: w_blank = (w_group[15:12] == 4'h0);
      default: w_blank = 1'b0;
    endcase
    w_blank = w_blank && BLANK_LZ;
  end

  always_comb begin
    w_glyph = 7'b1111111;
    unique case (w_nibble)
      4'h0: w_glyph = 7'b0000001;
      4'h1: w_glyph = 7'b1001111;
      4'h2: w_glyph = 7'b0010010;
      4'h3: w_glyph = 7'b0000110;
      4'h4: w_glyph = 7'b1001100;
      4'h5: w_glyph = 7'b0100100;
      4'h6: w_glyph = 7'b0100000;
      4'h7: w_glyph = 7'b0001111;
      4'h8: w_glyph = 7'b0000000;
      4'h9: w_glyph = 7'b0000100;
      4'hA: w_glyph = 7'b0001000;
      4'hB: w_glyph = 7'b1100000;
      4'hC: w_glyph = 7'b0110001;
      4'hD: w_glyph = 7'b1000010;
      4'hE: w_glyph = 7'b0110000;
      4'hF: w_glyph = 7'b0111000;
      default: w_glyph = 7'b1111111;
    endcase
  end

  assign bus.out7       = w_blank ? 7'b1111111 : w_glyph;
  // All digits stay off in slot cycle 0 so segment changes never ghost onto a neighbour.
  assign bus.en_out     = (r_cnt == '0) ? 8'hFF : ~(8'd1 << r_digit_idx);
  assign bus.digit_idx  = r_digit_idx;
  assign bus.frame_done = r_frame_done;

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Consumes the register-file debug taps (v0/v1) or WriteData/ProgramCounter from the pipelined datapath and drives an 8-digit multiplexed seven-segment display.

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; legal range >= 2.
REQ-002 Parameter BLANK_LZ, default 1: 1 enables leading-zero blanking per 4-digit group; 0 disables it.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  capture strobe for number_a and number_b.
REQ-006 number_a  input  16  value shown on digits 3..0 (digit 0 rightmost).
REQ-007 number_b  input  16  value shown on digits 7..4.
REQ-008 out7  output  7  active-low segments {a,b,c,d,e,f,g}, with a at bit 6.
REQ-009 en_out  output  8  active-low digit enables; bit n drives digit n.
REQ-010 digit_idx  output  3  index of the digit currently being scanned.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each 8-digit frame.

Function
REQ-012 Holding registers a_q and b_q shall load number_a and number_b on any rising edge with load=1, and hold otherwise.
- No other path shall update a_q or b_q.
REQ-013 A loaded value shall be visible on out7 on the cycle after the capture edge, including in the middle of a frame.
REQ-014 Refresh counter cnt shall count 0..REFRESH_DIV-1 and wrap to 0.
REQ-015 On the edge where cnt=REFRESH_DIV-1, digit_idx shall increment modulo 8 (7 wraps to 0); digit_idx shall hold on all other edges.
REQ-016 frame_done shall be registered and equal 1 for exactly the cycle after the edge on which digit_idx wraps 7->0.
REQ-017 Digit data selection:
- digit n (0..3) shows a_q[4n+3:4n];
- digit n (4..7) shows b_q[4(n-4)+3:4(n-4)].
REQ-018 The decoder shall produce active-low hex glyphs:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110;
- 4=1001100, 5=0100100, 6=0100000, 7=0001111;
- 8=0000000, 9=0000100, A=0001000, b=1100000;
- C=0110001, d=1000010, E=0110000, F=0111000.
REQ-019 Blanking with BLANK_LZ=1: a digit shall output out7=7'b1111111 when its nibble and every higher nibble in the same group are zero.
- Digits 0 and 4 shall never be blanked.
REQ-020 Ghosting guard: en_out shall be 8'hFF while cnt=0.
REQ-021 When cnt!=0, en_out shall have only bit digit_idx low.
REQ-022 out7 and en_out shall be combinational functions of the registered state (cnt, digit_idx, a_q, b_q) only, with no combinational path from any input.
REQ-023 When load=1 on the same edge as a digit advance, both updates shall take effect on that edge; neither has priority and neither is lost.

Reset
REQ-024 When rst=1 at a rising edge, the following shall become 0 on that edge: a_q, b_q, cnt, digit_idx, frame_done.
- The resulting outputs are en_out=8'hFF and out7=7'b0000001 (glyph 0, digit 0).
REQ-025 rst shall take priority over load and over counting.
REQ-026 Reset asserted mid-frame shall abandon the frame without producing a frame_done pulse.
REQ-027 While rst is held, the outputs shall remain at the REQ-024 reset values.

Verification (REFRESH_DIV=4, BLANK_LZ=1 unless stated)
REQ-028 Reset then load number_a=16'h1234 -> digit 0 slot shows:
- cnt=0: en_out=FF;
- cnt=1..3: en_out=FE, out7=1001100 (glyph 4).
- Next slot: en_out=FD, out7=0000110 (glyph 3).
REQ-029 Free-run for 32 cycles after reset -> digit_idx steps 0..7 every 4 cycles and frame_done pulses exactly once, in cycle 33.
REQ-030 With a_q=16'h0005, BLANK_LZ=1 -> digits 3..1 show 1111111 and digit 0 shows 0100100.
- Same stimulus with BLANK_LZ=0 -> digits 3..1 show 0000001.
REQ-031 With number_b=16'hABCD, load pulsed while digit_idx=4 and cnt=2 -> out7 shows d (1000010) from the next cycle; a_q is unchanged.
REQ-032 rst asserted at digit_idx=6, cnt=3 -> on the next cycle:
- digit_idx=0, cnt=0, en_out=FF, a_q=b_q=0;
- no frame_done pulse occurs.
REQ-033 load=1 coincident with a digit advance -> the new digit_idx and the new value are both reflected on the following cycle.
